// File: rtl/step_pulse_shaper.sv
// step_pulse_shaper
//   Buffers one-cycle step/dir events from the speed integrator as a signed
//   pending-step count and replays them as STEP/DIR waveforms that meet the
//   driver's DIR setup, STEP high width and STEP low width requirements.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   step_in       one-cycle step event
//   dir_in        direction of step_in (1 = +1, 0 = -1)
//   enable        allows new pulses to start
//   flush         clears the pending count this cycle
//   clr_overflow  clears the sticky overflow flag
//   dir_setup     cycles DIR is stable before STEP rises (0 allowed)
//   pulse_len     STEP high cycles (0 treated as 1)
//   low_len       STEP low cycles after a pulse, also DIR hold (0 treated as 1)
//   step_out      STEP pin (registered)
//   dir_out       DIR pin (registered)
//   busy          FSM is not idle
//   pending       signed pending-step count
//   overflow      sticky: an input step was dropped at saturation
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | waiting for enable and a non-zero pending count
// DIR_SETUP   | DIR driven to the new direction, counting setup time
// PULSE_HIGH  | STEP high; one pending step consumed on entry
// PULSE_LOW   | STEP low time, DIR held
module step_pulse_shaper #(
    parameter int CNT_W = 8,
    parameter int TMR_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    step_in,
    input  logic                    dir_in,
    input  logic                    enable,
    input  logic                    flush,
    input  logic                    clr_overflow,
    input  logic [TMR_W-1:0]        dir_setup,
    input  logic [TMR_W-1:0]        pulse_len,
    input  logic [TMR_W-1:0]        low_len,
    output logic                    step_out,
    output logic                    dir_out,
    output logic                    busy,
    output logic signed [CNT_W-1:0] pending,
    output logic                    overflow
);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_DIR_SETUP  = 2'd1;
    localparam logic [1:0] S_PULSE_HIGH = 2'd2;
    localparam logic [1:0] S_PULSE_LOW  = 2'd3;

    localparam logic signed [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic signed [CNT_W-1:0] CNT_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] CNT_MIN  = -CNT_MAX;

    // Two guard bits so the net sum can be formed without wrapping.
    localparam logic signed [CNT_W+1:0] ONE_W     = 1;
    localparam logic signed [CNT_W+1:0] MAX_W     = {2'b00, CNT_MAX};
    localparam logic signed [CNT_W+1:0] NEG_MAX_W = -MAX_W;

    localparam logic [TMR_W-1:0] TMR_ONE = 1;

    logic [1:0]              state_q, state_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic signed [CNT_W-1:0] pending_q, pending_d;
    logic                    dir_q, dir_d;
    logic                    step_q, step_d;
    logic                    overflow_q, overflow_d;

    logic                    want;
    logic                    enter_high;
    logic                    in_inc, in_dec, drop;
    logic signed [CNT_W+1:0] sum_w;

    // max(x,1)-1: the value a timer is loaded with for an x-cycle interval.
    function automatic logic [TMR_W-1:0] load_val(input logic [TMR_W-1:0] x);
        return (x == '0) ? '0 : (x - TMR_ONE);
    endfunction

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        dir_d      = dir_q;
        enter_high = 1'b0;
        want       = (pending_q > CNT_ZERO);

        case (state_q)
            S_IDLE: begin
                if (enable && (pending_q != CNT_ZERO) && !flush) begin
                    if ((want == dir_q) && (dir_setup == '0)) begin
                        state_d    = S_PULSE_HIGH;
                        timer_d    = load_val(pulse_len);
                        enter_high = 1'b1;
                    end else begin
                        // Same direction with a non-zero setup still goes through
                        // DIR_SETUP so the setup time is always honoured.
                        dir_d   = want;
                        state_d = S_DIR_SETUP;
                        timer_d = load_val(dir_setup);
                    end
                end
            end
            S_DIR_SETUP: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (timer_q == '0) begin
                    state_d    = S_PULSE_HIGH;
                    timer_d    = load_val(pulse_len);
                    enter_high = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            S_PULSE_HIGH: begin
                if (timer_q == '0) begin
                    state_d = S_PULSE_LOW;
                    timer_d = load_val(low_len);
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            default: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
        endcase

        step_d = (state_d == S_PULSE_HIGH);
    end

    always_comb begin
        in_inc = step_in && dir_in;
        in_dec = step_in && !dir_in;
        drop   = !flush && ((in_inc && (pending_q == CNT_MAX)) ||
                            (in_dec && (pending_q == CNT_MIN)));

        sum_w = {{2{pending_q[CNT_W-1]}}, pending_q};
        if (in_inc && !drop) sum_w = sum_w + ONE_W;
        if (in_dec && !drop) sum_w = sum_w - ONE_W;
        // The issued step is in the direction already on the DIR pin.
        if (enter_high) begin
            if (dir_q) sum_w = sum_w - ONE_W;
            else       sum_w = sum_w + ONE_W;
        end

        // A flush during DIR_SETUP can leave the issue opposing an empty count;
        // clamp so the most-negative code never appears.
        if (flush) begin
            pending_d = '0;
        end else if (sum_w > MAX_W) begin
            pending_d = CNT_MAX;
        end else if (sum_w < NEG_MAX_W) begin
            pending_d = CNT_MIN;
        end else begin
            pending_d = sum_w[CNT_W-1:0];
        end

        overflow_d = overflow_q;
        if (clr_overflow) overflow_d = 1'b0;
        if (drop)         overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            pending_q  <= '0;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            overflow_q <= overflow_d;
        end
    end

    assign step_out = step_q;
    assign dir_out  = dir_q;
    assign busy     = (state_q != S_IDLE);
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_step_pulse_shaper.sv
// Directed bench for step_pulse_shaper. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge.
module tb_step_pulse_shaper;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              step_in = 1'b0;
    logic              dir_in = 1'b0;
    logic              enable = 1'b0;
    logic              flush = 1'b0;
    logic              clr_overflow = 1'b0;
    logic [15:0]       dir_setup = '0;
    logic [15:0]       pulse_len = '0;
    logic [15:0]       low_len = '0;
    logic              step_out;
    logic              dir_out;
    logic              busy;
    logic signed [7:0] pending;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    int rise_cnt = 0;
    int dir_viol = 0;
    logic prev_step = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_dir = 1'b0;

    step_pulse_shaper #(.CNT_W(8), .TMR_W(16)) dut (
        .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in),
        .enable(enable), .flush(flush), .clr_overflow(clr_overflow),
        .dir_setup(dir_setup), .pulse_len(pulse_len), .low_len(low_len),
        .step_out(step_out), .dir_out(dir_out), .busy(busy),
        .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Counts STEP rising edges and any DIR change while the FSM was already busy.
    always @(negedge clk) begin
        if (reset) begin
            prev_step = 1'b0;
            prev_busy = 1'b0;
            prev_dir  = dir_out;
        end else begin
            if (step_out && !prev_step) rise_cnt++;
            if (prev_busy && (dir_out !== prev_dir)) dir_viol++;
            prev_step = step_out;
            prev_busy = busy;
            prev_dir  = dir_out;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic d);
        step_in = s;
        dir_in  = d;
        tick();
        step_in = 1'b0;
    endtask

    task automatic set_cfg(input int ds, input int pl, input int ll);
        dir_setup = 16'(ds);
        pulse_len = 16'(pl);
        low_len   = 16'(ll);
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        while ((busy || pending != 8'sd0) && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (busy || pending != 8'sd0) begin
            errors++;
            $display("FAIL %s_idle: busy=%0b pending=%0d, required idle with pending 0", name, busy, pending);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({step_out, dir_out, busy, overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: step/dir/busy/ovf=%b required 0000", {step_out, dir_out, busy, overflow});
        end
        checks++;
        if (pending !== 8'sd0) begin
            errors++;
            $display("FAIL reset_pending: got %0d required 0", pending);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_step();
        set_cfg(0, 3, 2);
        enable = 1'b1;
        drive(1'b1, 1'b1);
        wait_idle(30, "prime");
        checks++;
        if (dir_out !== 1'b1) begin
            errors++;
            $display("FAIL prime_dir: got %b required 1", dir_out);
        end
        drive(1'b1, 1'b1);
        checks++;
        if (pending !== 8'sd1 || step_out !== 1'b0) begin
            errors++;
            $display("FAIL single_c1: pending=%0d step=%b required 1,0", pending, step_out);
        end
        tick();
        checks++;
        if (pending !== 8'sd0 || step_out !== 1'b1) begin
            errors++;
            $display("FAIL single_rise: pending=%0d step=%b required 0,1", pending, step_out);
        end
        tick();
        tick();
        checks++;
        if (step_out !== 1'b1) begin
            errors++;
            $display("FAIL single_high3: step=%b required 1", step_out);
        end
        tick();
        checks++;
        if (step_out !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_low: step=%b busy=%b required 0,1", step_out, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_low2: busy=%b required 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: busy=%b required 0", busy);
        end
    endtask

    task automatic test_zero_len();
        set_cfg(0, 0, 0);
        drive(1'b1, 1'b1);
        tick();
        checks++;
        if (step_out !== 1'b1) begin
            errors++;
            $display("FAIL zero_rise: step=%b required 1", step_out);
        end
        tick();
        checks++;
        if (step_out !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_high1: step=%b busy=%b required 0,1", step_out, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_low1: busy=%b required 0", busy);
        end
    endtask

    task automatic test_dir_flip();
        int n = 0;
        set_cfg(4, 1, 1);
        drive(1'b1, 1'b0);
        checks++;
        if (pending !== -8'sd1 || dir_out !== 1'b1) begin
            errors++;
            $display("FAIL flip_c1: pending=%0d dir=%b required -1,1", pending, dir_out);
        end
        tick();
        checks++;
        if (dir_out !== 1'b0 || step_out !== 1'b0) begin
            errors++;
            $display("FAIL flip_dir: dir=%b step=%b required 0,0", dir_out, step_out);
        end
        while (!step_out && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL flip_setup: %0d cycles DIR->STEP, required 4", n);
        end
        checks++;
        if (pending !== 8'sd0) begin
            errors++;
            $display("FAIL flip_pend: got %0d required 0", pending);
        end
        wait_idle(20, "flip");
    endtask

    task automatic test_burst();
        int rises[$];
        logic prev = 1'b0;
        set_cfg(0, 1, 1);
        for (int c = 0; c < 60; c++) begin
            if (step_out && !prev) rises.push_back(c);
            prev = step_out;
            step_in = (c < 10);
            dir_in  = 1'b1;
            tick();
        end
        step_in = 1'b0;
        checks++;
        if (rises.size() != 10) begin
            errors++;
            $display("FAIL burst_count: got %0d pulses required 10", rises.size());
        end
        for (int i = 1; i < rises.size(); i++) begin
            checks++;
            if (rises[i] - rises[i-1] != 3) begin
                errors++;
                $display("FAIL burst_period: pulse %0d period %0d required 3", i, rises[i] - rises[i-1]);
            end
        end
        checks++;
        if (overflow !== 1'b0 || pending !== 8'sd0) begin
            errors++;
            $display("FAIL burst_end: ovf=%b pending=%0d required 0,0", overflow, pending);
        end
    endtask

    task automatic test_saturation();
        int start;
        set_cfg(0, 1, 1);
        enable = 1'b0;
        for (int i = 0; i < 130; i++) drive(1'b1, 1'b1);
        checks++;
        if (pending !== 8'sd127 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_level: pending=%0d ovf=%b required 127,1", pending, overflow);
        end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0 || pending !== 8'sd127) begin
            errors++;
            $display("FAIL sat_clr: ovf=%b pending=%0d required 0,127", overflow, pending);
        end
        clr_overflow = 1'b1;
        drive(1'b1, 1'b1);
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_setwins: ovf=%b required 1", overflow);
        end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        start = rise_cnt;
        enable = 1'b1;
        wait_idle(600, "sat");
        tick();
        checks++;
        if (rise_cnt - start != 127) begin
            errors++;
            $display("FAIL sat_pulses: got %0d pulses required 127", rise_cnt - start);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL sat_ovf_end: ovf=%b required 0", overflow);
        end
    endtask

    task automatic test_interleave_flush();
        int hi;
        set_cfg(0, 4, 4);
        enable = 1'b1;
        checks++;
        if (dir_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mix_start: dir=%b busy=%b required 1,0", dir_out, busy);
        end
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        checks++;
        if (step_out !== 1'b1 || pending !== 8'sd1) begin
            errors++;
            $display("FAIL mix_cancel: step=%b pending=%0d required 1,1", step_out, pending);
        end
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        checks++;
        if (pending !== -8'sd1 || dir_out !== 1'b1 || step_out !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mix_net: pending=%0d dir=%b step=%b busy=%b required -1,1,0,1",
                     pending, dir_out, step_out, busy);
        end
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        checks++;
        if (step_out !== 1'b1 || pending !== -8'sd4 || dir_out !== 1'b0) begin
            errors++;
            $display("FAIL mix_rev: step=%b pending=%0d dir=%b required 1,-4,0", step_out, pending, dir_out);
        end
        flush = 1'b1;
        drive(1'b1, 1'b0);
        flush = 1'b0;
        checks++;
        if (pending !== 8'sd0 || step_out !== 1'b1) begin
            errors++;
            $display("FAIL mix_flush: pending=%0d step=%b required 0,1", pending, step_out);
        end
        hi = 2;
        for (int k = 0; k < 10 && step_out; k++) begin
            tick();
            if (step_out) hi++;
        end
        checks++;
        if (hi != 4) begin
            errors++;
            $display("FAIL mix_complete: high %0d cycles required 4", hi);
        end
        wait_idle(30, "mix");
        checks++;
        if (dir_viol != 0) begin
            errors++;
            $display("FAIL dir_stable: %0d DIR changes while busy, required 0", dir_viol);
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        int start;
        set_cfg(0, 10, 1);
        enable = 1'b0;
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1);
        enable = 1'b1;
        while (!step_out && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (step_out !== 1'b1 || pending !== 8'sd5 || dir_out !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: step=%b pending=%0d dir=%b required 1,5,1", step_out, pending, dir_out);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({step_out, dir_out, busy} !== 3'b000 || pending !== 8'sd0) begin
            errors++;
            $display("FAIL areset_now: step/dir/busy=%b pending=%0d required 000,0",
                     {step_out, dir_out, busy}, pending);
        end
        tick();
        tick();
        reset = 1'b0;
        set_cfg(0, 1, 1);
        start = rise_cnt;
        drive(1'b1, 1'b1);
        wait_idle(30, "areset");
        tick();
        checks++;
        if (rise_cnt - start != 1 || dir_out !== 1'b1) begin
            errors++;
            $display("FAIL areset_resume: pulses=%0d dir=%b required 1,1", rise_cnt - start, dir_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_zero_len();
        test_dir_flip();
        test_burst();
        test_saturation();
        test_interleave_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
